code_lock: RTL and testbench
============================

CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: number of 4-bit digits per code.
REQ-002 SHALL have parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16: lockout duration in clk cycles.
REQ-004 SHALL have parameter DEFAULT_CODE, default 16'h1234: code loaded at reset, CODE_LEN*4 bits.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-006 SHALL have rst  input  1  synchronous active-high reset.
REQ-007 SHALL have digit  input  4  entered digit, 0..15.
REQ-008 SHALL have digit_valid  input  1  digit strobe, one digit per high cycle.
REQ-009 SHALL have code_in  input  CODE_LEN*4  new code value.
REQ-010 SHALL have code_load  input  1  request to replace stored code.
REQ-011 SHALL have lock  input  1  request to re-lock from OPEN.
REQ-012 SHALL have unlock  output  1  level, high while in OPEN.
REQ-013 SHALL have error  output  1  one-cycle pulse on failed attempt.
REQ-014 SHALL have locked_out  output  1  level, high while in LOCKOUT.
REQ-015 SHALL have digit_cnt  output  $clog2(CODE_LEN+1)  digits accepted in current attempt.

Function
REQ-016 SHALL implement states ENTRY, OPEN, LOCKOUT; all outputs registered.
REQ-017 SHALL compare digit k (k = 0 first) against stored code nibble [(CODE_LEN-1-k)*4 +: 4], MSB nibble first.
REQ-018 SHALL, in ENTRY on digit_valid, increment digit_cnt and set a sticky mismatch flag when the nibble differs.
REQ-019 SHALL, on the CODE_LEN-th digit, go to OPEN if no mismatch including that digit; unlock high the next cycle.
REQ-020 SHALL, on the CODE_LEN-th digit with any mismatch, pulse error next cycle, increment fail count, clear digit_cnt and mismatch flag, stay in ENTRY.
REQ-021 SHALL enter LOCKOUT instead of ENTRY when that failure makes fail count equal MAX_FAIL; error still pulses.
REQ-022 SHALL, in LOCKOUT, count LOCKOUT_CYCLES cycles, then return to ENTRY with fail count and digit_cnt cleared.
REQ-023 SHALL clear fail count on every successful attempt.
REQ-024 SHALL ignore digit_valid in OPEN and LOCKOUT; digit_cnt held at 0 there.
REQ-025 SHALL accept code_load only in OPEN; ignored elsewhere with no state change.
REQ-026 SHALL, on lock in OPEN, return to ENTRY with digit_cnt 0; on code_load and lock in same cycle, load the code and return to ENTRY.
REQ-027 SHALL make a newly loaded code effective from the first digit of the next attempt.
REQ-028 SHALL never reveal which digit mismatched before the final digit: error only after CODE_LEN digits.

Reset
REQ-029 SHALL on rst: state ENTRY, stored code DEFAULT_CODE, unlock 0, error 0, locked_out 0, digit_cnt 0, fail count 0, lockout counter 0.
REQ-030 SHALL let rst override every input in the same cycle, including mid-attempt and mid-lockout.

Structure
REQ-031 SHALL place the state enum type and default parameter values in shared package code_lock_pkg.
REQ-032 SHALL instantiate the existing comp_4bits (A = digit, B = selected code nibble, EQ) as its sole sub-module for the digit compare.

Verification
REQ-033 SHALL cover: reset, digits 1,2,3,4 -> unlock 1 cycle after 4th digit, error never pulses.
REQ-034 SHALL cover: digits 1,2,9,4 -> error pulse once after 4th digit, unlock 0, digit_cnt returns 0.
REQ-035 SHALL cover: three wrong attempts -> locked_out 1 for exactly 16 cycles; digits during it ignored; then 1,2,3,4 unlocks.
REQ-036 SHALL cover: in OPEN, code_in 16'hABCD with code_load and lock same cycle -> ENTRY; 1,2,3,4 fails; A,B,C,D unlocks.
REQ-037 SHALL cover: rst after 2 digits and mid-lockout -> all outputs at reset values next cycle; code back to 16'h1234.
REQ-038 SHALL cover: code_load in ENTRY with 16'h0000 -> ignored; 1,2,3,4 still unlocks.

Source files
------------

// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types and default parameter values for the code lock.
//   state_e            - lock FSM states
//   DEF_CODE_LEN       - digits per code
//   DEF_MAX_FAIL       - consecutive failures before lockout
//   DEF_LOCKOUT_CYCLES - lockout duration in clock cycles
//   DEF_CODE           - code loaded at reset
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam int          DEF_CODE_LEN       = 4;
    localparam int          DEF_MAX_FAIL       = 3;
    localparam int          DEF_LOCKOUT_CYCLES = 16;
    localparam logic [15:0] DEF_CODE           = 16'h1234;

endpackage

// File: rtl/comp_4bits.sv
// comp_4bits: 4-bit equality comparator.
//   A  - first operand
//   B  - second operand
//   EQ - high when A == B
module comp_4bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       EQ
);
    assign EQ = (A == B);
endmodule

// File: rtl/code_lock.sv
// code_lock: digit-entry code lock with failure lockout and field-updatable code.
//   clk, rst     - clock, synchronous active-high reset
//   digit        - entered digit (one per digit_valid cycle)
//   digit_valid  - digit strobe
//   code_in      - replacement code, accepted with code_load while OPEN
//   code_load    - replace stored code (OPEN only)
//   lock         - re-lock from OPEN
//   unlock       - high while OPEN
//   error        - one-cycle pulse after a failed attempt
//   locked_out   - high while in LOCKOUT
//   digit_cnt    - digits accepted in the current attempt
module code_lock
    import code_lock_pkg::*;
#(
    parameter int                    CODE_LEN       = DEF_CODE_LEN,
    parameter int                    MAX_FAIL       = DEF_MAX_FAIL,
    parameter int                    LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = DEF_CODE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [3:0]                      digit,
    input  logic                            digit_valid,
    input  logic [CODE_LEN*4-1:0]           code_in,
    input  logic                            code_load,
    input  logic                            lock,
    output logic                            unlock,
    output logic                            error,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [CODE_LEN*4-1:0] code_q, code_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  mism_q, mism_d;
    logic [FW-1:0]         fail_q, fail_d;
    logic [LW-1:0]         lo_q, lo_d;
    logic                  error_d;

    // Digit k is checked against the k-th nibble counting from the MSB end.
    logic [3:0] code_nib;
    logic       dig_eq;
    int         shamt;

    always_comb begin
        shamt    = (CODE_LEN - 1 - int'(cnt_q)) * 4;
        code_nib = 4'(code_q >> shamt);
    end

    comp_4bits u_comp (
        .A  (digit),
        .B  (code_nib),
        .EQ (dig_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ENTRY;
            code_q     <= DEFAULT_CODE;
            cnt_q      <= '0;
            mism_q     <= 1'b0;
            fail_q     <= '0;
            lo_q       <= '0;
            unlock     <= 1'b0;
            error      <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            mism_q     <= mism_d;
            fail_q     <= fail_d;
            lo_q       <= lo_d;
            unlock     <= (state_d == ST_OPEN);
            error      <= error_d;
            locked_out <= (state_d == ST_LOCKOUT);
        end
    end

    assign digit_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
        fail_d  = fail_q;
        lo_d    = lo_q;
        error_d = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (digit_valid) begin
                    if (cnt_q == CW'(CODE_LEN - 1)) begin
                        // Verdict only on the final digit, so a wrong digit
                        // earlier in the attempt is never exposed.
                        cnt_d  = '0;
                        mism_d = 1'b0;
                        if (mism_q || !dig_eq) begin
                            error_d = 1'b1;
                            fail_d  = fail_q + 1'b1;
                            if (fail_q == FW'(MAX_FAIL - 1)) begin
                                state_d = ST_LOCKOUT;
                                lo_d    = '0;
                            end
                        end else begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        mism_d = mism_q | ~dig_eq;
                    end
                end
            end
            ST_OPEN: begin
                if (code_load) code_d = code_in;
                if (lock)      state_d = ST_ENTRY;
            end
            ST_LOCKOUT: begin
                if (lo_q == LW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    mism_d  = 1'b0;
                end else begin
                    lo_d = lo_q + 1'b1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

endmodule

// File: tb/tb_code_lock.sv
module tb_code_lock;
    localparam int CODE_LEN       = 4;
    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int CW             = $clog2(CODE_LEN + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit = '0;
    logic        digit_valid = 1'b0;
    logic [15:0] code_in = '0;
    logic        code_load = 1'b0;
    logic        lock = 1'b0;
    logic        unlock, error, locked_out;
    logic [CW-1:0] digit_cnt;

    always #5 clk = ~clk;

    code_lock #(
        .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
        .code_in(code_in), .code_load(code_load), .lock(lock),
        .unlock(unlock), .error(error), .locked_out(locked_out),
        .digit_cnt(digit_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the digits of the current attempt and judges
    // the whole attempt once it is complete.
    int          m_mode;   // 0 entry, 1 open, 2 lockout
    logic [15:0] m_code;
    int          m_q[$];
    int          m_fails;
    int          m_left;
    bit          m_err;

    function automatic logic [3:0] nib(input logic [15:0] c, input int k);
        return 4'((c >> ((CODE_LEN - 1 - k) * 4)) & 16'hF);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_code = 16'h1234; m_q.delete(); m_fails = 0; m_left = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit r, input logic [3:0] d, input bit v,
                                       input logic [15:0] ci, input bit cl, input bit lk);
        bit ok;
        m_err = 0;
        if (r) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (v) begin
                m_q.push_back(int'(d));
                if (m_q.size() == CODE_LEN) begin
                    ok = 1;
                    for (int k = 0; k < CODE_LEN; k++)
                        if (m_q[k] != int'(nib(m_code, k))) ok = 0;
                    m_q.delete();
                    if (ok) begin
                        m_mode = 1; m_fails = 0;
                    end else begin
                        m_err = 1; m_fails++;
                        if (m_fails == MAX_FAIL) begin
                            m_mode = 2; m_left = LOCKOUT_CYCLES;
                        end
                    end
                end
            end
            1: begin
                if (cl) m_code = ci;
                if (lk) m_mode = 0;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0; m_fails = 0;
                end
            end
        endcase
    endfunction

    task automatic apply(input bit r, input logic [3:0] d, input bit v,
                         input logic [15:0] ci, input bit cl, input bit lk);
        rst = r; digit = d; digit_valid = v; code_in = ci; code_load = cl; lock = lk;
        model_step(r, d, v, ci, cl, lk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".unlock"},     32'(unlock),     32'(m_mode == 1));
        check({tag, ".error"},      32'(error),      32'(m_err));
        check({tag, ".locked_out"}, 32'(locked_out), 32'(m_mode == 2));
        check({tag, ".digit_cnt"},  32'(digit_cnt),  32'(m_q.size()));
    endtask

    task automatic enter(input logic [15:0] code);
        for (int k = 0; k < CODE_LEN; k++) apply(0, nib(code, k), 1, 16'h0, 0, 0);
    endtask

    typedef struct {
        bit r; logic [3:0] d; bit v; logic [15:0] ci; bit cl; bit lk;
        bit e_un; bit e_err; bit e_lo; int e_cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit r, input logic [3:0] d, input bit v,
                                input logic [15:0] ci, input bit cl, input bit lk,
                                input bit un, input bit er, input bit lo, input int cnt);
        vec_t t;
        t = '{r, d, v, ci, cl, lk, un, er, lo, cnt};
        tbl.push_back(t);
    endfunction

    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Correct code, OPEN, digits ignored in OPEN, re-lock
        add(1, 0, 0, 16'h0,    0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 16'h0,    0, 0, 0, 0, 0, 1);
        add(0, 2, 1, 16'h0,    0, 0, 0, 0, 0, 2);
        add(0, 3, 1, 16'h0,    0, 0, 0, 0, 0, 3);
        add(0, 4, 1, 16'h0,    0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0,    0, 0, 1, 0, 0, 0);
        add(0, 7, 1, 16'h0,    0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0,    0, 1, 0, 0, 0, 0);
        // Wrong third digit: error only after the fourth
        add(0, 1, 1, 16'h0,    0, 0, 0, 0, 0, 1);
        add(0, 2, 1, 16'h0,    0, 0, 0, 0, 0, 2);
        add(0, 9, 1, 16'h0,    0, 0, 0, 0, 0, 3);
        add(0, 4, 1, 16'h0,    0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 0);
        // code_load outside OPEN is ignored
        add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 16'h0,    0, 0, 0, 0, 0, 1);
        add(0, 2, 1, 16'h0,    0, 0, 0, 0, 0, 2);
        add(0, 3, 1, 16'h0,    0, 0, 0, 0, 0, 3);
        add(0, 4, 1, 16'h0,    0, 0, 1, 0, 0, 0);
        // Load ABCD with lock in the same cycle
        add(0, 0, 0, 16'hABCD, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 16'h0,    0, 0, 0, 0, 0, 1);
        add(0, 2, 1, 16'h0,    0, 0, 0, 0, 0, 2);
        add(0, 3, 1, 16'h0,    0, 0, 0, 0, 0, 3);
        add(0, 4, 1, 16'h0,    0, 0, 0, 1, 0, 0);
        add(0, 10, 1, 16'h0,   0, 0, 0, 0, 0, 1);
        add(0, 11, 1, 16'h0,   0, 0, 0, 0, 0, 2);
        add(0, 12, 1, 16'h0,   0, 0, 0, 0, 0, 3);
        add(0, 13, 1, 16'h0,   0, 0, 1, 0, 0, 0);
        // code_load alone stays OPEN; new code used on next attempt
        add(0, 0, 0, 16'h1234, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0,    0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 16'h0,    0, 0, 0, 0, 0, 1);
        add(0, 2, 1, 16'h0,    0, 0, 0, 0, 0, 2);
        add(0, 3, 1, 16'h0,    0, 0, 0, 0, 0, 3);
        add(0, 4, 1, 16'h0,    0, 0, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].ci, tbl[i].cl, tbl[i].lk);
            check($sformatf("vec%0d.unlock", i),     32'(unlock),     32'(tbl[i].e_un));
            check($sformatf("vec%0d.error", i),      32'(error),      32'(tbl[i].e_err));
            check($sformatf("vec%0d.locked_out", i), 32'(locked_out), 32'(tbl[i].e_lo));
            check($sformatf("vec%0d.digit_cnt", i),  32'(digit_cnt),  32'(tbl[i].e_cnt));
        end

        // Three wrong attempts -> lockout lasting exactly LOCKOUT_CYCLES cycles
        apply(1, 0, 0, 16'h0, 0, 0);
        check_model("lo_reset");
        for (int a = 0; a < MAX_FAIL; a++) begin
            enter(16'h0000);
            check($sformatf("lo_att%0d.error", a),      32'(error),      32'd1);
            check($sformatf("lo_att%0d.locked_out", a), 32'(locked_out), 32'(a == MAX_FAIL - 1));
        end
        n = 1;
        while (locked_out === 1'b1 && n < 40) begin
            apply(0, 4'($urandom_range(0, 15)), 1, 16'h0, 1, 1);
            check("lo_ignore.digit_cnt", 32'(digit_cnt), 32'd0);
            if (locked_out === 1'b1) n++;
        end
        check("lo_duration", 32'(n), 32'(LOCKOUT_CYCLES));
        model_reset();
        enter(16'h1234);
        check("lo_after.unlock", 32'(unlock), 32'd1);
        check("lo_after.error",  32'(error),  32'd0);

        // Reset mid-attempt overrides all other inputs
        apply(1, 0, 0, 16'h0, 0, 0);
        apply(0, 1, 1, 16'h0, 0, 0);
        apply(0, 2, 1, 16'h0, 0, 0);
        apply(1, 3, 1, 16'hFFFF, 1, 1);
        check_model("rst_mid");
        enter(16'h1234);
        check("rst_mid.reopen", 32'(unlock), 32'd1);

        // Reset mid-lockout restores the default code
        apply(0, 0, 0, 16'hABCD, 1, 1);
        for (int a = 0; a < MAX_FAIL; a++) enter(16'h1111);
        for (int c = 0; c < 5; c++) apply(0, 0, 0, 16'h0, 0, 0);
        check("rst_lo.pre", 32'(locked_out), 32'd1);
        apply(1, 1, 1, 16'hABCD, 1, 1);
        check_model("rst_lo");
        enter(16'h1234);
        check("rst_lo.default_code", 32'(unlock), 32'd1);

        // Randomized run against the model
        apply(1, 0, 0, 16'h0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0]  d;
            logic [15:0] ci;
            if (m_mode == 0 && $urandom_range(0, 7) != 0) d = nib(m_code, m_q.size());
            else d = 4'($urandom_range(0, 15));
            ci = ($urandom_range(0, 1) == 0) ? 16'h1234 : 16'($urandom);
            apply($urandom_range(0, 399) == 0, d, $urandom_range(0, 1) == 1, ci,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
